// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract controller.
// A single full-adder slice (two half-adder stages plus a carry flop) is
// stepped over N-bit operands LSB first, one bit per clock.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           operation request, sampled when the block can accept
//   sub             0 = a+b, 1 = a-b (captured with the operands)
//   a, b            N-bit operands (captured at an accepted start)
//   busy            high while the bit-serial pass is running
//   done            one-cycle pulse, s/c/ovf valid from this cycle on
//   s, c, ovf       result, carry out (for sub: 1 = no borrow), signed overflow
module serial_adder_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         c,
    output logic         ovf
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   sum_sr;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic           accept_c;
    logic           shift_c;
    logic           last_c;

    logic           p;
    logic           g1;
    logic           g2;
    logic           sbit;
    logic           cnext;

    // State register; busy/done are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Next-state logic. The DONE exit edge also samples start so that
    // back-to-back requests complete at one operation per N+1 cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CW'(N - 1)) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        accept_c = 1'b0;
        shift_c  = 1'b0;
        last_c   = 1'b0;
        case (state)
            IDLE: accept_c = start;
            RUN: begin
                shift_c = 1'b1;
                last_c  = (cnt == CW'(N - 1));
            end
            DONE:    accept_c = start;
            default: ;
        endcase
    end

    // Adder slice: two half-adder stages sharing the carry flop.
    always_comb begin
        p     = a_sr[0] ^ b_sr[0];
        g1    = a_sr[0] & b_sr[0];
        sbit  = p ^ carry;
        g2    = p & carry;
        cnext = g1 | g2;
    end

    // Operand/sum shift registers, carry, counter and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            c      <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept_c) begin
            // Subtraction is a + ~b + 1: invert b and preset the carry.
            a_sr   <= a;
            b_sr   <= sub ? ~b : b;
            sum_sr <= '0;
            carry  <= sub;
            cnt    <= '0;
        end else if (shift_c) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {sbit, sum_sr[N-1:1]};
            carry  <= cnext;
            cnt    <= cnt + CW'(1);
            if (last_c) begin
                // Overflow: carry into the sign bit differs from carry out.
                s   <= {sbit, sum_sr[N-1:1]};
                c   <= cnext;
                ovf <= carry ^ cnext;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: three instances (N = 2, 8, 32) run random
// operations against an arithmetic reference; the N=8 instance first runs
// directed cases with literal expected results, a reset abort and
// back-to-back requests. Expected results go into per-instance queues and
// a monitor pops them on each done pulse.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h required 0x%0h", name, cyc, act, req);
        end
    endtask

    // Reference: {ovf, c, s} for a w-bit add/subtract, from plain arithmetic.
    function automatic logic [33:0] ref_op(input int w, input bit sv,
                                           input longint unsigned av, input longint unsigned bv);
        longint m, half, x, y, sum, sx, sy, r;
        logic [31:0] sres;
        bit cy, ov;
        m    = longint'(1) << w;
        half = m / 2;
        x    = longint'(av);
        y    = longint'(bv);
        if (sv) begin
            sum = x - y;
            cy  = (x >= y);
        end else begin
            sum = x + y;
            cy  = (sum >= m);
        end
        sres = 32'(((sum % m) + m) % m);
        sx   = (x >= half) ? x - m : x;
        sy   = (y >= half) ? y - m : y;
        r    = sv ? sx - sy : sx + sy;
        ov   = (r < -half) || (r >= half);
        return {ov, cy, sres};
    endfunction

    function automatic logic [33:0] lit(input logic [31:0] sv, input bit cv, input bit ov);
        return {ov, cv, sv};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_ch
        localparam int unsigned NV = (g == 0) ? 2 : (g == 1) ? 8 : 32;
        localparam int NI = NV;

        logic          rst_i = 1'b1;
        logic          start_i = 1'b0;
        logic          sub_i = 1'b0;
        logic [NV-1:0] a_i = '0;
        logic [NV-1:0] b_i = '0;
        logic          busy_o;
        logic          done_o;
        logic [NV-1:0] s_o;
        logic          c_o;
        logic          ovf_o;

        logic [33:0]   exp_q[$];
        int            edge_q[$];
        int            last_acc = -1000;
        int            rst_edge = -1000;
        int            next_free = 0;
        int            n_acc = 0;
        bit            fin_b = 1'b0;

        serial_adder_ctrl #(.N(NV)) dut (
            .clk   (clk),
            .rst   (rst_i),
            .start (start_i),
            .sub   (sub_i),
            .a     (a_i),
            .b     (b_i),
            .busy  (busy_o),
            .done  (done_o),
            .s     (s_o),
            .c     (c_o),
            .ovf   (ovf_o)
        );

        // Drive one cycle of inputs for the next edge and record whether the
        // request is accepted there (one op per NV+1 edges, reset wins).
        task automatic drive(input bit st, input logic [NV-1:0] av, input logic [NV-1:0] bv,
                             input bit sv, input bit rv, input bit has_lit, input logic [33:0] lv);
            int e;
            @(negedge clk);
            rst_i   = rv;
            start_i = st;
            a_i     = av;
            b_i     = bv;
            sub_i   = sv;
            e = cyc + 1;
            if (rv) begin
                rst_edge  = e;
                next_free = e + 1;
                exp_q.delete();
                edge_q.delete();
            end else if (st && e >= next_free) begin
                last_acc  = e;
                next_free = e + NI + 1;
                n_acc++;
                exp_q.push_back(has_lit ? lv : ref_op(NI, sv, 64'(av), 64'(bv)));
                edge_q.push_back(e + NI);
            end
        endtask

        task automatic rand_drive(input bit st);
            drive(st, NV'($urandom), NV'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
        endtask

        // Accepted op, then NV cycles of random start pulses and operand
        // changes while running, then one idle cycle.
        task automatic dir_op(input logic [NV-1:0] av, input logic [NV-1:0] bv,
                              input bit sv, input logic [33:0] lv);
            drive(1'b1, av, bv, sv, 1'b0, 1'b1, lv);
            for (int i = 0; i < NI; i++) rand_drive(1'($urandom_range(0, 1)));
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        endtask

        initial begin
            int base;
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
            if (NI == 8) begin
                dir_op(NV'(8'h5A), NV'(8'h3C), 1'b0, lit(32'h96, 1'b0, 1'b1));
                dir_op(NV'(8'hFF), NV'(8'h01), 1'b0, lit(32'h00, 1'b1, 1'b0));
                dir_op(NV'(8'h7F), NV'(8'h01), 1'b0, lit(32'h80, 1'b0, 1'b1));
                dir_op(NV'(8'h10), NV'(8'h20), 1'b1, lit(32'hF0, 1'b0, 1'b0));
                dir_op(NV'(8'h80), NV'(8'h01), 1'b1, lit(32'h7F, 1'b1, 1'b1));
                // start held high: back-to-back operations
                repeat (3 * (NI + 1)) rand_drive(1'b1);
                repeat (NI + 1) rand_drive(1'b0);
                // reset while bit 4 is processed, with start also high
                drive(1'b1, NV'(8'h5A), NV'(8'h3C), 1'b0, 1'b0, 1'b1, lit(32'h96, 1'b0, 1'b1));
                repeat (4) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
                drive(1'b1, NV'(8'h11), NV'(8'h22), 1'b0, 1'b1, 1'b0, '0);
                drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
                dir_op(NV'(8'h5A), NV'(8'h3C), 1'b0, lit(32'h96, 1'b0, 1'b1));
            end
            base = n_acc;
            while (n_acc < base + 1000) rand_drive($urandom_range(0, 7) != 0);
            for (int i = 0; i < 4 * NI + 8 && exp_q.size() != 0; i++) rand_drive(1'b0);
            check(exp_q.size() == 0, $sformatf("N%0d drain", NI), exp_q.size(), 0);
            fin_b = 1'b1;
        end

        always @(negedge clk) begin : mon
            bit          busy_exp;
            logic [33:0] e;
            int          t;
            busy_exp = (cyc >= last_acc) && (cyc <= last_acc + NI - 1)
                       && !(rst_edge > last_acc && cyc >= rst_edge);
            check(busy_o === busy_exp, $sformatf("N%0d busy", NI), busy_o, busy_exp);
            check(!(busy_o === 1'b1 && done_o === 1'b1), $sformatf("N%0d busy_done_excl", NI),
                  {busy_o, done_o}, 0);
            if (cyc == rst_edge)
                check({busy_o, done_o, c_o, ovf_o, s_o} === '0, $sformatf("N%0d reset_state", NI),
                      {busy_o, done_o, c_o, ovf_o, s_o}, 0);
            if (done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, $sformatf("N%0d spurious_done", NI), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    t = edge_q.pop_front();
                    check(t == cyc, $sformatf("N%0d done_cycle", NI), cyc, t);
                    check({ovf_o, c_o, s_o} === {e[33:32], e[NV-1:0]},
                          $sformatf("N%0d result{ovf,c,s}", NI),
                          {ovf_o, c_o, s_o}, {e[33:32], e[NV-1:0]});
                end
            end else if (edge_q.size() != 0 && edge_q[0] <= cyc) begin
                check(1'b0, $sformatf("N%0d missing_done", NI), cyc, edge_q[0]);
                void'(exp_q.pop_front());
                void'(edge_q.pop_front());
            end
        end
    end

    initial begin
        bit all_fin;
        all_fin = 1'b0;
        for (int i = 0; i < 90000 && !all_fin; i++) begin
            @(posedge clk);
            all_fin = gen_ch[0].fin_b && gen_ch[1].fin_b && gen_ch[2].fin_b;
        end
        check(all_fin, "run_timeout", all_fin, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
